// File: rtl/key_schedule_seq.sv
// Sequential DES-family key schedule: loads one post-PC1 key, then emits ROUNDS round keys.
// Optional macro KEY_SCHED_PC2_EN applies the DES PC2 selection to produce 48-bit round keys.
module key_schedule_seq #(
    parameter int unsigned HALF_W    = 28,
    parameter int unsigned ROUNDS    = 16,
    parameter logic [63:0] SHIFT_MAP = 64'h7EFC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [2*HALF_W-1:0] key_in,
    input  logic                key_decrypt,
    output logic                rk_valid,
    input  logic                rk_ready,
`ifdef KEY_SCHED_PC2_EN
    output logic [47:0]         rk_data,
`else
    output logic [2*HALF_W-1:0] rk_data,
`endif
    output logic [5:0]          rk_round,
    output logic                rk_last
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x,
                                               input int unsigned n);
        int unsigned m;
        m = n % HALF_W;
        // A shift by HALF_W yields zero, so m == 0 degenerates to the identity.
        return (x << m) | (x >> (HALF_W - m));
    endfunction

    function automatic int unsigned sh(input int unsigned r);
        return SHIFT_MAP[r[5:0]] ? 2 : 1;
    endfunction

    function automatic int unsigned total_shift();
        int unsigned s;
        s = 0;
        for (int unsigned r = 0; r < ROUNDS; r++) begin
            s += sh(r);
        end
        return s % HALF_W;
    endfunction

    localparam int unsigned TOTAL = total_shift();
    localparam int unsigned SH0   = sh(0);

    state_e            state_q, state_d;
    logic [HALF_W-1:0] c_q, c_d, d_q, d_d;
    logic [5:0]        round_q, round_d;
    logic              decrypt_q, decrypt_d;

    logic [HALF_W-1:0] key_c, key_d;
    logic [HALF_W-1:0] c_step, d_step;
    logic [5:0]        enc_idx, dec_idx;
    logic              step2;
    logic              last_round;
    logic              in_run;

    assign key_c      = key_in[2*HALF_W-1:HALF_W];
    assign key_d      = key_in[HALF_W-1:0];
    assign in_run     = (state_q == StRun);
    assign last_round = (round_q == 6'(ROUNDS - 1));

    assign rk_valid   = in_run;
    assign rk_round   = round_q;
    assign rk_last    = in_run & last_round;
    // Combinational from rk_ready so a new key can load on the final handshake.
    assign key_ready  = (state_q == StIdle) | (in_run & last_round & rk_ready);

    // Encrypt looks ahead to the next round's shift; decrypt undoes the current one.
    always_comb begin
        enc_idx = round_q + 6'd1;
        dec_idx = 6'(ROUNDS - 1) - round_q;
        step2   = decrypt_q ? SHIFT_MAP[dec_idx] : SHIFT_MAP[enc_idx];
        c_step  = c_q;
        d_step  = d_q;
        unique case ({decrypt_q, step2})
            2'b00: begin c_step = rotl(c_q, 1);          d_step = rotl(d_q, 1);          end
            2'b01: begin c_step = rotl(c_q, 2);          d_step = rotl(d_q, 2);          end
            2'b10: begin c_step = rotl(c_q, HALF_W - 1); d_step = rotl(d_q, HALF_W - 1); end
            2'b11: begin c_step = rotl(c_q, HALF_W - 2); d_step = rotl(d_q, HALF_W - 2); end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        d_d       = d_q;
        round_d   = round_q;
        decrypt_d = decrypt_q;
        if (key_valid && key_ready) begin
            state_d   = StRun;
            round_d   = '0;
            decrypt_d = key_decrypt;
            if (key_decrypt) begin
                c_d = rotl(key_c, TOTAL);
                d_d = rotl(key_d, TOTAL);
            end else begin
                c_d = rotl(key_c, SH0);
                d_d = rotl(key_d, SH0);
            end
        end else if (in_run && rk_ready) begin
            if (last_round) begin
                state_d = StIdle;
                round_d = '0;
            end else begin
                round_d = round_q + 6'd1;
                c_d     = c_step;
                d_d     = d_step;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            c_q       <= '0;
            d_q       <= '0;
            round_q   <= '0;
            decrypt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            d_q       <= d_d;
            round_q   <= round_d;
            decrypt_q <= decrypt_d;
        end
    end

`ifdef KEY_SCHED_PC2_EN
    if (HALF_W != 28) begin : g_pc2_width_check
        $error("KEY_SCHED_PC2_EN requires HALF_W == 28");
    end

    // Entries are 1-based positions counted from the MSB of the 56-bit CD value.
    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] y;
        y = '0;
        for (int unsigned j = 0; j < 48; j++) begin
            y[47 - j] = cd[56 - PC2_TAB[j]];
        end
        return y;
    endfunction

    assign rk_data = pc2({c_q, d_q});
`else
    assign rk_data = {c_q, d_q};
`endif

endmodule

// File: tb/tb_key_schedule_seq.sv
// Self-checking bench for key_schedule_seq: vector table, scoreboard monitor, corner sequences.
module tb_key_schedule_seq;

`ifdef KEY_SCHED_PC2_EN
    localparam int RK_W = 48;
`else
    localparam int RK_W = 56;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            key_valid;
    logic            key_ready;
    logic [55:0]     key_in;
    logic            key_decrypt;
    logic            rk_valid;
    logic            rk_ready;
    logic [RK_W-1:0] rk_data;
    logic [5:0]      rk_round;
    logic            rk_last;

    key_schedule_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_in      (key_in),
        .key_decrypt (key_decrypt),
        .rk_valid    (rk_valid),
        .rk_ready    (rk_ready),
        .rk_data     (rk_data),
        .rk_round    (rk_round),
        .rk_last     (rk_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
        logic [27:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[26:0], y[27]};
        return y;
    endfunction

`ifdef KEY_SCHED_PC2_EN
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [47:0] pc2_m(input logic [55:0] cd);
        logic [47:0] y;
        y = '0;
        for (int j = 0; j < 48; j++) y[47 - j] = cd[56 - PC2_T[j]];
        return y;
    endfunction
`endif

    function automatic logic [RK_W-1:0] model_k(input logic [55:0] key, input int r);
        int s;
        logic [55:0] cd;
        s = 0;
        for (int i = 0; i <= r; i++) s += SHIFTS[i];
        cd = {rotl28(key[55:28], s), rotl28(key[27:0], s)};
`ifdef KEY_SCHED_PC2_EN
        return pc2_m(cd);
`else
        return cd;
`endif
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [RK_W-1:0] data;
        logic [5:0]      round;
        logic            last;
    } exp_t;

    exp_t sb_q[$];

    task automatic push_key(input logic [55:0] k, input logic dec);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.data  = model_k(k, dec ? 15 - i : i);
            e.round = 6'(i);
            e.last  = (i == 15);
            sb_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rk_valid && rk_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_key", 64'(rk_round), 64'hFFFF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_data", 64'(rk_data), 64'(e.data));
                    check("sb_round", 64'(rk_round), 64'(e.round));
                    check("sb_last", 64'(rk_last), 64'(e.last));
                end
            end
            if (key_valid && key_ready) push_key(key_in, key_decrypt);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Call at posedge+1; returns at posedge+1 right after the key is accepted.
    task automatic send_key(input logic [55:0] k, input logic dec);
        bit ok;
        ok = 0;
        key_in      = k;
        key_decrypt = dec;
        key_valid   = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (key_ready) ok = 1;
        end
        check("key_accept", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        key_valid   = 1'b0;
        key_in      = {$urandom, $urandom};
        key_decrypt = ~dec;
    endtask

    task automatic wait_round(input logic [5:0] r);
        bit ok;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (rk_valid && rk_round == r) ok = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("wait_round", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && rk_valid; i++) begin
            @(posedge clk);
            #1;
        end
        check("idle_rk_valid", 64'(rk_valid), 64'd0);
        check("idle_key_ready", 64'(key_ready), 64'd1);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [55:0]     key;
        logic            dec;
        logic [RK_W-1:0] first;
        logic [RK_W-1:0] last;
    } vec_t;

`ifdef KEY_SCHED_PC2_EN
    localparam int NV = 2;
`else
    localparam int NV = 5;
`endif
    vec_t vecs [NV];

    logic [55:0] ka, kb, kc;

    initial begin
`ifdef KEY_SCHED_PC2_EN
        vecs[0] = '{56'hF0CCAAF556678F, 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
        vecs[1] = '{56'hF0CCAAF556678F, 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
`else
        vecs[0] = '{56'hF0CCAAF556678F, 1'b0, 56'hE19955FAACCF1E, 56'hF0CCAAF556678F};
        vecs[1] = '{56'hF0CCAAF556678F, 1'b1, 56'hF0CCAAF556678F, 56'hE19955FAACCF1E};
        vecs[2] = '{56'h00000000000001, 1'b0, 56'h00000000000002, 56'h00000000000001};
        vecs[3] = '{56'h00000000000001, 1'b1, 56'h00000000000001, 56'h00000000000002};
        vecs[4] = '{56'h80000000000000, 1'b0, 56'h00000010000000, 56'h80000000000000};
`endif
        ka = 56'h13579BDF2468AC;
        kb = 56'hFEDCBA98765432;
        kc = 56'h0F1E2D3C4B5A69;

        rst_n       = 1'b0;
        key_valid   = 1'b0;
        key_in      = '0;
        key_decrypt = 1'b0;
        rk_ready    = 1'b1;
        #2;
        check("rst_rk_valid", 64'(rk_valid), 64'd0);
        check("rst_rk_data", 64'(rk_data), 64'd0);
        check("rst_rk_round", 64'(rk_round), 64'd0);
        check("rst_rk_last", 64'(rk_last), 64'd0);
        check("rst_key_ready", 64'(key_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < NV; v++) begin
            send_key(vecs[v].key, vecs[v].dec);
            check("vec_first_valid", 64'(rk_valid), 64'd1);
            check("vec_first_round", 64'(rk_round), 64'd0);
            check("vec_first_data", 64'(rk_data), 64'(vecs[v].first));
            check("vec_key_ready_busy", 64'(key_ready), 64'd0);
            wait_round(6'd15);
            check("vec_last_flag", 64'(rk_last), 64'd1);
            check("vec_last_data", 64'(rk_data), 64'(vecs[v].last));
            @(posedge clk);
            #1;
            check("vec_after_last_valid", 64'(rk_valid), 64'd0);
            wait_idle();
        end

        // Backpressure at round 3.
        send_key(ka, 1'b0);
        wait_round(6'd3);
        rk_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 64'(rk_valid), 64'd1);
            check("bp_round", 64'(rk_round), 64'd3);
            check("bp_data", 64'(rk_data), 64'(model_k(ka, 3)));
            check("bp_key_ready", 64'(key_ready), 64'd0);
        end
        rk_ready = 1'b1;
        wait_idle();

        // Back-to-back: new decrypt key offered during the final handshake.
        send_key(ka, 1'b0);
        wait_round(6'd15);
        check("b2b_key_ready", 64'(key_ready), 64'd1);
        send_key(kb, 1'b1);
        check("b2b_valid_held", 64'(rk_valid), 64'd1);
        check("b2b_round", 64'(rk_round), 64'd0);
        check("b2b_data", 64'(rk_data), 64'(model_k(kb, 15)));
        wait_idle();

        // Reset mid-run at round 7.
        send_key(kb, 1'b0);
        wait_round(6'd7);
        rst_n = 1'b0;
        #1;
        check("mrst_rk_valid", 64'(rk_valid), 64'd0);
        check("mrst_key_ready", 64'(key_ready), 64'd1);
        check("mrst_rk_round", 64'(rk_round), 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_idle_after_release", 64'(rk_valid), 64'd0);
        send_key(kc, 1'b0);
        check("mrst_new_round", 64'(rk_round), 64'd0);
        check("mrst_new_data", 64'(rk_data), 64'(model_k(kc, 0)));
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_schedule_seq.md
Name: key_schedule_seq

Overview:
- Sequential DES-family key schedule generator.
- Accepts one post-PC1 key through a valid/ready handshake, then emits ROUNDS round keys one per handshake, in encrypt order (left rotations) or decrypt order (right rotations, reversed sequence).
- Generalises the single-round C/D rotate step to a configurable half-width, round count and shift map, with backpressure.
- Sits between the PC1 stage and the round datapath.

Parameters:
- HALF_W, 28, width of each C/D half; the key is 2*HALF_W bits.
- ROUNDS, 16, number of round keys per key load (2..64).
- SHIFT_MAP, 16'h7EFC, ROUNDS-bit mask. Bit r=1 means encrypt round r (0-indexed) rotates by 2; bit r=0 means it rotates by 1. The default gives DES shifts 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- key_valid  in  1  key offered.
- key_ready  out  1  block can accept a key this cycle.
- key_in  in  2*HALF_W  post-PC1 key; C = upper half, D = lower half.
- key_decrypt  in  1  sampled with the key; 1 = decrypt order.
- rk_valid  out  1  round key valid.
- rk_ready  in  1  consumer accepts the round key.
- rk_data  out  RK_W  round key; RK_W = 2*HALF_W, or 48 with the optional feature.
- rk_round  out  6  index of the emitted key, 0..ROUNDS-1, counting from the first emitted key.
- rk_last  out  1  high with rk_valid when rk_round == ROUNDS-1.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state IDLE; C/D registers 0; round counter 0; mode 0.
  - Outputs: rk_valid 0, rk_data 0, rk_round 0, rk_last 0, key_ready 1.
  - Reset asserted mid-sequence aborts immediately. No partial key is emitted after release.
- Definitions:
  - sh(r) = SHIFT_MAP[r] ? 2 : 1.
  - S_r = sum of sh(0..r), taken mod HALF_W.
  - K_r = {rotl(C0,S_r), rotl(D0,S_r)}.
  - TOTAL = S_(ROUNDS-1) is a localparam computed at elaboration. For DES it is 28 ≡ 0.
- States: IDLE and RUN.
- IDLE:
  - key_ready = 1.
  - On key_valid & key_ready, the key is loaded, the mode latched, round = 0, and the state moves to RUN.
  - The loaded CD is K_0 = rotl by sh(0) when encrypting, or K_(ROUNDS-1) = rotl by TOTAL when decrypting.
  - Latency from key accept to rk_valid is 1 cycle.
- RUN:
  - rk_valid = 1, with rk_data, rk_round and rk_last driven from registers.
  - Outputs are held stable while rk_ready = 0.
  - On a handshake with round < ROUNDS-1: round++.
    - Encrypt: CD = rotl(CD, sh(round+1)).
    - Decrypt: CD = rotr(CD, sh(ROUNDS-1-round)).
    - Rotation applies independently to each half.
  - On a handshake with round == ROUNDS-1: return to IDLE and clear rk_valid next cycle, unless a new key is accepted in the same cycle.
- Back-to-back keys:
  - key_ready = IDLE | (RUN & rk_last & rk_ready). This is a combinational path from rk_ready.
  - A key accepted on the final handshake reloads directly. The next cycle shows round 0 of the new key with rk_valid held at 1, so there is no bubble.
- Mode and key_in are ignored outside the accept cycle. Changes to key_decrypt during RUN have no effect.
- Decrypt emits K_(ROUNDS-1) down to K_0. rk_round still counts 0 upward.
- rk_data is a registered output with no combinational path from key_in.

Optional Feature:
- Macro: KEY_SCHED_PC2_EN.
- Defined:
  - rk_data is 48 bits: the standard DES PC2 selection applied combinationally to the CD register.
  - HALF_W must equal 28; any other value is an elaboration error.
- Undefined: rk_data = raw {C,D}, 2*HALF_W bits, and no PC2 logic exists.

Test Plan:
- Encrypt, raw CD, defaults, rk_ready = 1: key_in = 56'hF0CCAAF556678F, key_decrypt = 0 -> cycle +1 gives rk_data = 56'hE19955FAACCF1E, rk_round = 0. Sixteen consecutive keys follow. Key 15 = 56'hF0CCAAF556678F with rk_last = 1, then rk_valid = 0.
- Encrypt, KEY_SCHED_PC2_EN defined, same key -> first rk_data = 48'h1B02EFFC7072, last = 48'hCB3D8B0E17F5.
- Decrypt, PC2 enabled, same key -> first rk_data = 48'hCB3D8B0E17F5, last = 48'h1B02EFFC7072. The full sequence is the exact reverse of the encrypt run.
- Backpressure: rk_ready low for 5 cycles at round 3 -> rk_data and rk_round = 3 held stable, key_ready = 0, no skipped or duplicated key.
- Back-to-back: second key presented with key_valid held during the final handshake -> accepted that cycle, next cycle rk_round = 0 of the new key, rk_valid never drops.
- Reset mid-run: rst_n pulled low at round 7 -> rk_valid = 0 and key_ready = 1 immediately. After release, a new key starts at round 0.
